// File: rtl/single_cycle_cpu.sv
// single_cycle_cpu: 32-bit MIPS-subset core with a CPI of 1.
// The core reads instructions from an external combinational instruction memory.
// Data memory is external: reads are combinational and writes happen on the rising edge.
// Optional feature macro: SINGLE_CYCLE_JAL_JR_EN adds jal, jr and jalr.
//   When the macro is undefined, those encodings execute as NOPs.
module single_cycle_cpu #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DATA_W   = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [31:0]       instruction,
  input  logic [DATA_W-1:0] mem_read_data,
  output logic [31:0]       PC,
  output logic [DATA_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_write_data,
  output logic              mem_wr
);

  logic [5:0]  opcode;
  logic [4:0]  rs;
  logic [4:0]  rt;
  logic [4:0]  rd;
  logic [4:0]  shamt;
  logic [5:0]  funct;
  logic [15:0] imm16;
  logic [25:0] imm26;

  assign opcode = instruction[31:26];
  assign rs     = instruction[25:21];
  assign rt     = instruction[20:16];
  assign rd     = instruction[15:11];
  assign shamt  = instruction[10:6];
  assign funct  = instruction[5:0];
  assign imm16  = instruction[15:0];
  assign imm26  = instruction[25:0];

  logic [DATA_W-1:0] rf [0:31];
  logic [DATA_W-1:0] rs_val;
  logic [DATA_W-1:0] rt_val;
  logic signed [DATA_W-1:0] rs_s;
  logic signed [DATA_W-1:0] rt_s;
  logic signed [DATA_W-1:0] sext_imm;
  logic [DATA_W-1:0] zext_imm;
  logic [31:0]       pc_plus4;
  logic [31:0]       branch_target;

  // $0 is hard-wired to zero. Reads see the pre-edge value, so a same-cycle write is not forwarded.
  assign rs_val   = (rs == 5'd0) ? '0 : rf[rs];
  assign rt_val   = (rt == 5'd0) ? '0 : rf[rt];
  assign rs_s     = rs_val;
  assign rt_s     = rt_val;
  assign sext_imm = {{(DATA_W-16){imm16[15]}}, imm16};
  assign zext_imm = {{(DATA_W-16){1'b0}}, imm16};
  assign pc_plus4 = PC + 32'd4;
  assign branch_target = pc_plus4 + {sext_imm[29:0], 2'b00};

  logic              reg_we;
  logic [4:0]        wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              mem_we;
  logic [31:0]       next_pc;

  // Decode the instruction and compute the write-back value and the next PC.
  // Any unrecognised encoding falls through to the defaults, which behave as a NOP.
  always_comb begin
    reg_we  = 1'b0;
    wr_addr = rt;
    wr_data = '0;
    mem_we  = 1'b0;
    next_pc = pc_plus4;
    case (opcode)
      6'h00: begin
        wr_addr = rd;
        case (funct)
          6'h20, 6'h21: begin reg_we = 1'b1; wr_data = rs_val + rt_val; end
          6'h22, 6'h23: begin reg_we = 1'b1; wr_data = rs_val - rt_val; end
          6'h24: begin reg_we = 1'b1; wr_data = rs_val & rt_val; end
          6'h25: begin reg_we = 1'b1; wr_data = rs_val | rt_val; end
          6'h26: begin reg_we = 1'b1; wr_data = rs_val ^ rt_val; end
          6'h27: begin reg_we = 1'b1; wr_data = ~(rs_val | rt_val); end
          6'h2A: begin reg_we = 1'b1; wr_data = {{(DATA_W-1){1'b0}}, (rs_s < rt_s)}; end
          6'h2B: begin reg_we = 1'b1; wr_data = {{(DATA_W-1){1'b0}}, (rs_val < rt_val)}; end
          6'h00: begin reg_we = 1'b1; wr_data = rt_val << shamt; end
          6'h02: begin reg_we = 1'b1; wr_data = rt_val >> shamt; end
          6'h03: begin reg_we = 1'b1; wr_data = rt_s >>> shamt; end
`ifdef SINGLE_CYCLE_JAL_JR_EN
          6'h08: next_pc = rs_val;
          6'h09: begin reg_we = 1'b1; wr_data = pc_plus4; next_pc = rs_val; end
`endif
          default: ;
        endcase
      end
      6'h08, 6'h09: begin reg_we = 1'b1; wr_data = rs_val + sext_imm; end
      6'h0A: begin reg_we = 1'b1; wr_data = {{(DATA_W-1){1'b0}}, (rs_s < sext_imm)}; end
      6'h0B: begin reg_we = 1'b1; wr_data = {{(DATA_W-1){1'b0}}, (rs_val < sext_imm)}; end
      6'h0C: begin reg_we = 1'b1; wr_data = rs_val & zext_imm; end
      6'h0D: begin reg_we = 1'b1; wr_data = rs_val | zext_imm; end
      6'h0E: begin reg_we = 1'b1; wr_data = rs_val ^ zext_imm; end
      6'h0F: begin reg_we = 1'b1; wr_data = {imm16, {(DATA_W-16){1'b0}}}; end
      6'h23: begin reg_we = 1'b1; wr_data = mem_read_data; end
      6'h2B: mem_we = 1'b1;
      6'h04: if (rs_val == rt_val) next_pc = branch_target;
      6'h05: if (rs_val != rt_val) next_pc = branch_target;
      6'h02: next_pc = {pc_plus4[31:28], imm26, 2'b00};
`ifdef SINGLE_CYCLE_JAL_JR_EN
      6'h03: begin
        reg_we  = 1'b1;
        wr_addr = 5'd31;
        wr_data = pc_plus4;
        next_pc = {pc_plus4[31:28], imm26, 2'b00};
      end
`endif
      default: ;
    endcase
  end

  assign mem_addr       = rs_val + sext_imm;
  assign mem_write_data = rt_val;
  // The write enable is gated by reset so that memory cannot be written while the core is held in reset.
  assign mem_wr         = mem_we & reset;

  // Update the program counter once per instruction.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) PC <= RESET_PC;
    else        PC <= next_pc;
  end

  // Register file write port. Writes to $0 are dropped.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 32; i++) rf[i] <= '0;
    end else if (reg_we && (wr_addr != 5'd0)) begin
      rf[wr_addr] <= wr_data;
    end
  end

endmodule

// File: tb/tb_single_cycle_cpu.sv
// Directed testbench for single_cycle_cpu. It builds with or without SINGLE_CYCLE_JAL_JR_EN.
// Register contents are observed through mem_addr by putting "lw $0,0(rN)" on the instruction port.
module tb_single_cycle_cpu;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] instruction;
  logic [31:0] mem_read_data;
  logic [31:0] PC;
  logic [31:0] mem_addr;
  logic [31:0] mem_write_data;
  logic        mem_wr;

  logic [31:0] dmem [0:63];
  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] exp_pc;

  single_cycle_cpu #(.RESET_PC(32'h0000_0000), .DATA_W(32)) dut (
    .clk            (clk),
    .reset          (reset),
    .instruction    (instruction),
    .mem_read_data  (mem_read_data),
    .PC             (PC),
    .mem_addr       (mem_addr),
    .mem_write_data (mem_write_data),
    .mem_wr         (mem_wr)
  );

  always #50 clk = ~clk;

  assign mem_read_data = dmem[mem_addr[7:2]];

  always @(posedge clk) begin
    if (mem_wr) dmem[mem_addr[7:2]] <= mem_write_data;
  end

  function automatic logic [31:0] rtype(input logic [4:0] s, input logic [4:0] t,
                                        input logic [4:0] d, input logic [4:0] sh,
                                        input logic [5:0] fn);
    return {6'h00, s, t, d, sh, fn};
  endfunction

  function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] s,
                                        input logic [4:0] t, input logic [15:0] imm);
    return {op, s, t, imm};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Read register r through mem_addr using lw $0,0(rN). The peek has no architectural effect.
  task automatic peek(input logic [4:0] r, input logic [31:0] exp);
    instruction = itype(6'h23, r, 5'd0, 16'h0000);
    #1;
    check($sformatf("reg%0d", r), mem_addr, exp);
  endtask

  // Execute one instruction on the next rising edge and check that the PC moves to the target.
  task automatic run_to(input logic [31:0] ins, input logic [31:0] target);
    instruction = ins;
    @(posedge clk);
    #1;
    exp_pc = target;
    check("pc", PC, exp_pc);
  endtask

  task automatic run(input logic [31:0] ins);
    run_to(ins, exp_pc + 32'd4);
  endtask

  initial begin
    reset       = 1'b0;
    instruction = 32'h0;
    exp_pc      = 32'h0;

    // Reset: hold reset low for two cycles and check that the PC, mem_wr and all registers are cleared.
    repeat (2) @(posedge clk);
    #1;
    check("reset_pc", PC, 32'h0);
    instruction = itype(6'h2B, 5'd0, 5'd1, 16'h0008);
    #1;
    check("reset_mem_wr", {31'b0, mem_wr}, 32'h0);
    for (int r = 1; r < 32; r++) peek(r[4:0], 32'h0);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("release_pc", PC, 32'h0);

    // Immediate and register ALU operations.
    run(itype(6'h08, 5'd0, 5'd1, 16'd5));
    peek(5'd1, 32'd5);
    run(itype(6'h08, 5'd0, 5'd2, 16'hFFFD));
    peek(5'd2, 32'hFFFF_FFFD);
    run(rtype(5'd1, 5'd2, 5'd3, 5'd0, 6'h20));
    peek(5'd3, 32'd2);
    run(rtype(5'd2, 5'd1, 5'd4, 5'd0, 6'h2B));
    peek(5'd4, 32'd0);

    // Branches: beq is at 0x10 and is taken; the first bne is not taken; the second bne is taken.
    check("pc_at_beq", PC, 32'h10);
    run_to(itype(6'h04, 5'd1, 5'd1, 16'd2), 32'h1C);
    run_to(itype(6'h05, 5'd1, 5'd1, 16'd2), 32'h20);
    run_to(itype(6'h05, 5'd1, 5'd2, 16'd2), 32'h2C);

    // Build a constant with lui and ori.
    run(itype(6'h0F, 5'd0, 5'd5, 16'h1234));
    run(itype(6'h0D, 5'd5, 5'd5, 16'h5678));
    peek(5'd5, 32'h1234_5678);

    // Memory: store, then check that mem_wr is not still asserted on the next instruction, then load.
    instruction = itype(6'h2B, 5'd0, 5'd5, 16'h0008);
    #1;
    check("sw_mem_wr", {31'b0, mem_wr}, 32'h1);
    check("sw_addr", mem_addr, 32'h8);
    check("sw_data", mem_write_data, 32'h1234_5678);
    run(instruction);
    instruction = itype(6'h23, 5'd0, 5'd6, 16'h0008);
    #1;
    check("lw_mem_wr", {31'b0, mem_wr}, 32'h0);
    check("lw_rdata", mem_read_data, 32'h1234_5678);
    run(instruction);
    peek(5'd6, 32'h1234_5678);

    // Jump to word address 0x40, which is byte address 0x100.
    run_to({6'h02, 26'h40}, 32'h100);

    // Edge cases and the remaining ALU operations.
    run(itype(6'h08, 5'd0, 5'd0, 16'd7));
    peek(5'd0, 32'h0);
    run(itype(6'h0F, 5'd0, 5'd7, 16'h7FFF));
    run(itype(6'h0D, 5'd7, 5'd7, 16'hFFFF));
    run(itype(6'h08, 5'd0, 5'd8, 16'd1));
    run(rtype(5'd7, 5'd8, 5'd9, 5'd0, 6'h20));
    peek(5'd9, 32'h8000_0000);
    run(rtype(5'd1, 5'd2, 5'd10, 5'd0, 6'h22));
    peek(5'd10, 32'd8);
    run(rtype(5'd2, 5'd1, 5'd11, 5'd0, 6'h2A));
    peek(5'd11, 32'd1);
    run(rtype(5'd0, 5'd9, 5'd12, 5'd4, 6'h03));
    peek(5'd12, 32'hF800_0000);
    run(rtype(5'd0, 5'd9, 5'd13, 5'd4, 6'h02));
    peek(5'd13, 32'h0800_0000);
    run(rtype(5'd0, 5'd1, 5'd14, 5'd3, 6'h00));
    peek(5'd14, 32'h28);
    run(rtype(5'd0, 5'd0, 5'd15, 5'd0, 6'h27));
    peek(5'd15, 32'hFFFF_FFFF);
    run(itype(6'h0A, 5'd2, 5'd16, 16'd5));
    peek(5'd16, 32'd1);
    run(itype(6'h0B, 5'd2, 5'd17, 16'd5));
    peek(5'd17, 32'd0);
    run(itype(6'h0B, 5'd1, 5'd18, 16'hFFFF));
    peek(5'd18, 32'd1);
    run(itype(6'h0C, 5'd2, 5'd19, 16'hFFFF));
    peek(5'd19, 32'h0000_FFFD);
    run(itype(6'h0E, 5'd1, 5'd20, 16'hFFFF));
    peek(5'd20, 32'h0000_FFFA);

    // An undefined opcode and an undefined funct must behave as NOPs.
    run(itype(6'h3F, 5'd1, 5'd9, 16'h0001));
    peek(5'd9, 32'h8000_0000);
    run(rtype(5'd1, 5'd1, 5'd9, 5'd0, 6'h3F));
    peek(5'd9, 32'h8000_0000);

    // Mid-run asynchronous reset, asserted between clock edges.
    instruction = itype(6'h2B, 5'd0, 5'd5, 16'h0008);
    #1;
    check("pre_rst_mem_wr", {31'b0, mem_wr}, 32'h1);
    #10;
    reset = 1'b0;
    #1;
    check("async_rst_pc", PC, 32'h0);
    check("async_rst_mem_wr", {31'b0, mem_wr}, 32'h0);
    peek(5'd5, 32'h0);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    exp_pc = 32'h0;
    #1;
    check("rst_release_pc", PC, 32'h0);

    // jal and jr: real jumps when the feature is built in, NOPs otherwise.
    for (int k = 0; k < 8; k++) run(32'h0);
`ifdef SINGLE_CYCLE_JAL_JR_EN
    run_to({6'h03, 26'h10}, 32'h40);
    peek(5'd31, 32'h24);
    run_to(rtype(5'd31, 5'd0, 5'd0, 5'd0, 6'h08), 32'h24);
`else
    run_to({6'h03, 26'h10}, 32'h24);
    peek(5'd31, 32'h0);
    run_to(rtype(5'd31, 5'd0, 5'd0, 5'd0, 6'h08), 32'h28);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
